// File: rtl/biu_constants_pkg.sv
// Shared bus-interface types for the BIU arbiter and its response queue.
// Holds transfer size/type/protection encodings, arbitration mode and FSM states.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3,
        QWORD = 3'd4
    } biu_size_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } biu_type_t;

    // Protection bits: {privileged, non-secure, instruction/data}
    typedef logic [2:0] biu_prot_t;
    localparam biu_prot_t PROT_DATA       = 3'b000;
    localparam biu_prot_t PROT_INSTR      = 3'b001;
    localparam biu_prot_t PROT_NONSECURE  = 3'b010;
    localparam biu_prot_t PROT_PRIVILEGED = 3'b100;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_HOLD = 2'd1,
        ST_LOCK = 2'd2
    } arb_state_t;

endpackage

// File: rtl/biu_resp_fifo.sv
// Small FIFO of port indices awaiting a downstream response.
// Head is read combinationally so responses route with zero latency.
module biu_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A push at full is only legal when the head leaves in the same cycle
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/biu_arbiter.sv
// Multi-port bus arbiter: picks one upstream port for the downstream BIU,
// supports locked sequences, and routes responses back via an in-order queue.
module biu_arbiter
    import biu_constants_pkg::*;
#(
    parameter int        ADDR_SIZE   = 32,
    parameter int        DATA_SIZE   = 32,
    parameter int        PORTS       = 2,
    parameter int        QUEUE_DEPTH = 2,
    parameter arb_mode_t ARB_MODE    = ARB_FIXED
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 biu_stb_i     [PORTS],
    input  logic [ADDR_SIZE-1:0] biu_adri_i    [PORTS],
    input  biu_size_t            biu_size_i    [PORTS],
    input  biu_type_t            biu_type_i    [PORTS],
    input  logic                 biu_lock_i    [PORTS],
    input  biu_prot_t            biu_prot_i    [PORTS],
    input  logic                 biu_we_i      [PORTS],
    input  logic [DATA_SIZE-1:0] biu_d_i       [PORTS],
    output logic                 biu_stb_ack_o [PORTS],
    output logic                 biu_d_ack_o   [PORTS],
    output logic [ADDR_SIZE-1:0] biu_adro_o    [PORTS],
    output logic [DATA_SIZE-1:0] biu_q_o       [PORTS],
    output logic                 biu_ack_o     [PORTS],
    output logic                 biu_err_o     [PORTS],

    output logic                 biu_stb_o,
    output logic [ADDR_SIZE-1:0] biu_adri_o,
    output biu_size_t            biu_size_o,
    output biu_type_t            biu_type_o,
    output logic                 biu_lock_o,
    output biu_prot_t            biu_prot_o,
    output logic                 biu_we_o,
    output logic [DATA_SIZE-1:0] biu_d_o,
    input  logic                 biu_stb_ack_i,
    input  logic                 biu_d_ack_i,
    input  logic [ADDR_SIZE-1:0] biu_adro_i,
    input  logic [DATA_SIZE-1:0] biu_q_i,
    input  logic                 biu_ack_i,
    input  logic                 biu_err_i,

    output logic                 busy_o,
    output logic                 orphan_o
);

    localparam int PORT_SIZE = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CNT_W     = $clog2(QUEUE_DEPTH + 1);

    arb_state_t           state_reg;
    arb_state_t           state_next;
    logic [PORT_SIZE-1:0] grant_reg;
    logic [PORT_SIZE-1:0] last_reg;
    logic [PORT_SIZE-1:0] arb_grant;
    logic [PORT_SIZE-1:0] grant;
    logic [PORT_SIZE-1:0] head;
    logic [CNT_W-1:0]     queue_count;
    logic                 queue_empty;
    logic                 queue_full;
    logic                 accept;
    logic                 rsp;
    logic                 pop;
    logic                 orphan_reg;
    logic                 rr_found;
    int                   rr_idx;

    // Fixed priority lets the last (highest) requester win; round-robin
    // scans upward from the port after the most recently accepted one.
    always_comb begin
        arb_grant = '0;
        rr_found  = 1'b0;
        rr_idx    = 0;
        if (ARB_MODE == ARB_RR) begin
            for (int i = 1; i <= PORTS; i++) begin
                rr_idx = (int'(last_reg) + i) % PORTS;
                if (!rr_found && biu_stb_i[PORT_SIZE'(rr_idx)]) begin
                    arb_grant = PORT_SIZE'(rr_idx);
                    rr_found  = 1'b1;
                end
            end
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (biu_stb_i[PORT_SIZE'(p)]) begin
                    arb_grant = PORT_SIZE'(p);
                end
            end
        end
    end

    assign grant  = (state_reg == ST_ARB) ? arb_grant : grant_reg;
    assign accept = biu_stb_o & biu_stb_ack_i;
    assign rsp    = biu_ack_i | biu_err_i;
    assign pop    = rsp & ~queue_empty;

    // queue_full comes from the registered count, so a same-cycle pop never unblocks stb
    assign biu_stb_o  = rst_ni & biu_stb_i[grant] & ~queue_full;
    assign biu_adri_o = biu_adri_i[grant];
    assign biu_size_o = biu_size_i[grant];
    assign biu_type_o = biu_type_i[grant];
    assign biu_lock_o = biu_lock_i[grant];
    assign biu_prot_o = biu_prot_i[grant];
    assign biu_we_o   = biu_we_i[grant];
    assign biu_d_o    = biu_d_i[grant];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ARB, ST_HOLD: begin
                if (accept) begin
                    state_next = biu_lock_i[grant] ? ST_LOCK : ST_ARB;
                end else if (biu_stb_o) begin
                    state_next = ST_HOLD;
                end
            end
            ST_LOCK: begin
                if (!biu_lock_i[grant] && !biu_stb_i[grant]) begin
                    state_next = ST_ARB;
                end
            end
            default: state_next = ST_ARB;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg  <= ST_ARB;
            grant_reg  <= '0;
            last_reg   <= PORT_SIZE'(PORTS - 1);
            orphan_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant;
            if (accept) begin
                last_reg <= grant;
            end
            if (rsp && queue_empty) begin
                orphan_reg <= 1'b1;
            end
        end
    end

    biu_resp_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (PORT_SIZE)
    ) u_resp_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (accept),
        .pop    (pop),
        .din    (grant),
        .head   (head),
        .empty  (queue_empty),
        .full   (queue_full),
        .count  (queue_count)
    );

    assign busy_o   = (queue_count != '0);
    assign orphan_o = orphan_reg;

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_port
            assign biu_stb_ack_o[gi] = accept & (grant == PORT_SIZE'(gi));
            assign biu_d_ack_o[gi]   = rst_ni & biu_d_ack_i & (grant == PORT_SIZE'(gi));
            assign biu_ack_o[gi]     = rst_ni & biu_ack_i & ~queue_empty & (head == PORT_SIZE'(gi));
            assign biu_err_o[gi]     = rst_ni & biu_err_i & ~queue_empty & (head == PORT_SIZE'(gi));
            assign biu_q_o[gi]       = biu_q_i;
            assign biu_adro_o[gi]    = biu_adro_i;
        end
    endgenerate

endmodule

// File: tb/tb_biu_arbiter.sv
// Directed bench: a 2-port fixed-priority arbiter driven from a vector table,
// plus hand sequences for reset/orphan handling and a 3-port round-robin arbiter.
module tb_biu_arbiter;
    import biu_constants_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Two-port fixed-priority instance
    logic          fx_stb [2];
    logic [AW-1:0] fx_adri [2];
    biu_size_t     fx_size [2];
    biu_type_t     fx_type [2];
    logic          fx_lock [2];
    biu_prot_t     fx_prot [2];
    logic          fx_we [2];
    logic [DW-1:0] fx_d [2];
    logic          fx_stb_ack [2];
    logic          fx_d_ack [2];
    logic [AW-1:0] fx_adro [2];
    logic [DW-1:0] fx_q [2];
    logic          fx_ack [2];
    logic          fx_err [2];
    logic          fx_stb_o, fx_lock_o, fx_we_o;
    logic [AW-1:0] fx_adr_o;
    biu_size_t     fx_size_o;
    biu_type_t     fx_type_o;
    biu_prot_t     fx_prot_o;
    logic [DW-1:0] fx_d_o;
    logic          fx_sack_i, fx_dack_i, fx_ack_i, fx_err_i;
    logic [AW-1:0] fx_adro_i;
    logic [DW-1:0] fx_q_i;
    logic          fx_busy, fx_orphan;

    // Three-port round-robin instance
    logic          rr_stb [3];
    logic [AW-1:0] rr_adri [3];
    biu_size_t     rr_size [3];
    biu_type_t     rr_type [3];
    logic          rr_lock [3];
    biu_prot_t     rr_prot [3];
    logic          rr_we [3];
    logic [DW-1:0] rr_d [3];
    logic          rr_stb_ack [3];
    logic          rr_d_ack [3];
    logic [AW-1:0] rr_adro [3];
    logic [DW-1:0] rr_q [3];
    logic          rr_ack [3];
    logic          rr_err [3];
    logic          rr_stb_o, rr_lock_o, rr_we_o;
    logic [AW-1:0] rr_adr_o;
    biu_size_t     rr_size_o;
    biu_type_t     rr_type_o;
    biu_prot_t     rr_prot_o;
    logic [DW-1:0] rr_d_o;
    logic          rr_sack_i, rr_dack_i, rr_ack_i, rr_err_i;
    logic [AW-1:0] rr_adro_i;
    logic [DW-1:0] rr_q_i;
    logic          rr_busy, rr_orphan;

    biu_arbiter #(
        .ADDR_SIZE (AW), .DATA_SIZE (DW), .PORTS (2), .QUEUE_DEPTH (2), .ARB_MODE (ARB_FIXED)
    ) dut_fx (
        .clk_i (clk), .rst_ni (rst_n),
        .biu_stb_i (fx_stb), .biu_adri_i (fx_adri), .biu_size_i (fx_size), .biu_type_i (fx_type),
        .biu_lock_i (fx_lock), .biu_prot_i (fx_prot), .biu_we_i (fx_we), .biu_d_i (fx_d),
        .biu_stb_ack_o (fx_stb_ack), .biu_d_ack_o (fx_d_ack), .biu_adro_o (fx_adro),
        .biu_q_o (fx_q), .biu_ack_o (fx_ack), .biu_err_o (fx_err),
        .biu_stb_o (fx_stb_o), .biu_adri_o (fx_adr_o), .biu_size_o (fx_size_o), .biu_type_o (fx_type_o),
        .biu_lock_o (fx_lock_o), .biu_prot_o (fx_prot_o), .biu_we_o (fx_we_o), .biu_d_o (fx_d_o),
        .biu_stb_ack_i (fx_sack_i), .biu_d_ack_i (fx_dack_i), .biu_adro_i (fx_adro_i), .biu_q_i (fx_q_i),
        .biu_ack_i (fx_ack_i), .biu_err_i (fx_err_i),
        .busy_o (fx_busy), .orphan_o (fx_orphan)
    );

    biu_arbiter #(
        .ADDR_SIZE (AW), .DATA_SIZE (DW), .PORTS (3), .QUEUE_DEPTH (8), .ARB_MODE (ARB_RR)
    ) dut_rr (
        .clk_i (clk), .rst_ni (rst_n),
        .biu_stb_i (rr_stb), .biu_adri_i (rr_adri), .biu_size_i (rr_size), .biu_type_i (rr_type),
        .biu_lock_i (rr_lock), .biu_prot_i (rr_prot), .biu_we_i (rr_we), .biu_d_i (rr_d),
        .biu_stb_ack_o (rr_stb_ack), .biu_d_ack_o (rr_d_ack), .biu_adro_o (rr_adro),
        .biu_q_o (rr_q), .biu_ack_o (rr_ack), .biu_err_o (rr_err),
        .biu_stb_o (rr_stb_o), .biu_adri_o (rr_adr_o), .biu_size_o (rr_size_o), .biu_type_o (rr_type_o),
        .biu_lock_o (rr_lock_o), .biu_prot_o (rr_prot_o), .biu_we_o (rr_we_o), .biu_d_o (rr_d_o),
        .biu_stb_ack_i (rr_sack_i), .biu_d_ack_i (rr_dack_i), .biu_adro_i (rr_adro_i), .biu_q_i (rr_q_i),
        .biu_ack_i (rr_ack_i), .biu_err_i (rr_err_i),
        .busy_o (rr_busy), .orphan_o (rr_orphan)
    );

    // in  = {stb0, stb1, lock0, lock1, stb_ack_i, d_ack_i, ack_i, err_i}
    // exp = {stb_o, stb_ack0, stb_ack1, d_ack0, d_ack1, ack0, ack1, err0, err1, busy, orphan}
    typedef struct {
        logic [7:0]  in;
        logic [11:0] adr;
        logic [10:0] exp;
    } vec_t;

    localparam int NVEC = 32;
    vec_t vecs [NVEC];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fx_idle();
        fx_stb[0] = 1'b0; fx_stb[1] = 1'b0; fx_lock[0] = 1'b0; fx_lock[1] = 1'b0;
        fx_sack_i = 1'b0; fx_dack_i = 1'b0; fx_ack_i = 1'b0; fx_err_i = 1'b0;
    endtask

    initial begin
        // Port1 hogs under fixed priority
        vecs[0]  = '{8'b1100_1000, 12'h200, 11'b1_01_00_00_00_0_0};
        vecs[1]  = '{8'b1100_1010, 12'h200, 11'b1_01_00_01_00_1_0};
        vecs[2]  = '{8'b1100_1010, 12'h200, 11'b1_01_00_01_00_1_0};
        vecs[3]  = '{8'b1100_1010, 12'h200, 11'b1_01_00_01_00_1_0};
        vecs[4]  = '{8'b0000_0010, 12'h100, 11'b0_00_00_01_00_1_0};
        vecs[5]  = '{8'b0000_0000, 12'h100, 11'b0_00_00_00_00_0_0};
        // Response ordering: port1 then port0, ack then err
        vecs[6]  = '{8'b0100_1000, 12'h200, 11'b1_01_00_00_00_0_0};
        vecs[7]  = '{8'b1000_1000, 12'h100, 11'b1_10_00_00_00_1_0};
        vecs[8]  = '{8'b0000_0010, 12'h100, 11'b0_00_00_01_00_1_0};
        vecs[9]  = '{8'b0000_0001, 12'h100, 11'b0_00_00_00_10_1_0};
        vecs[10] = '{8'b0000_0000, 12'h100, 11'b0_00_00_00_00_0_0};
        // Queue full blocks stb; ack unblocks only on the following cycle
        vecs[11] = '{8'b1000_1000, 12'h100, 11'b1_10_00_00_00_0_0};
        vecs[12] = '{8'b1000_1000, 12'h100, 11'b1_10_00_00_00_1_0};
        vecs[13] = '{8'b1000_1000, 12'h100, 11'b0_00_00_00_00_1_0};
        vecs[14] = '{8'b1000_1010, 12'h100, 11'b0_00_00_10_00_1_0};
        vecs[15] = '{8'b1000_1000, 12'h100, 11'b1_10_00_00_00_1_0};
        vecs[16] = '{8'b0000_0010, 12'h100, 11'b0_00_00_10_00_1_0};
        vecs[17] = '{8'b0000_0010, 12'h100, 11'b0_00_00_10_00_1_0};
        // HOLD freezes grant on port0 even when port1 appears
        vecs[18] = '{8'b1000_0000, 12'h100, 11'b1_00_00_00_00_0_0};
        vecs[19] = '{8'b1100_0000, 12'h100, 11'b1_00_00_00_00_0_0};
        vecs[20] = '{8'b1100_1000, 12'h100, 11'b1_10_00_00_00_0_0};
        vecs[21] = '{8'b0100_1010, 12'h200, 11'b1_01_00_10_00_1_0};
        vecs[22] = '{8'b0000_0010, 12'h100, 11'b0_00_00_01_00_1_0};
        // Locked sequence on port0 while port1 waits
        vecs[23] = '{8'b1010_1000, 12'h100, 11'b1_10_00_00_00_0_0};
        vecs[24] = '{8'b1110_1110, 12'h100, 11'b1_10_10_10_00_1_0};
        vecs[25] = '{8'b1110_1010, 12'h100, 11'b1_10_00_10_00_1_0};
        vecs[26] = '{8'b0110_1010, 12'h100, 11'b0_00_00_10_00_1_0};
        vecs[27] = '{8'b0100_1000, 12'h100, 11'b0_00_00_00_00_0_0};
        vecs[28] = '{8'b0100_1100, 12'h200, 11'b1_01_01_00_00_0_0};
        vecs[29] = '{8'b0000_0010, 12'h100, 11'b0_00_00_01_00_1_0};
        // Orphan response
        vecs[30] = '{8'b0000_0010, 12'h100, 11'b0_00_00_00_00_0_0};
        vecs[31] = '{8'b0000_0000, 12'h100, 11'b0_00_00_00_00_0_1};

        for (int p = 0; p < 2; p++) begin
            fx_adri[p] = AW'(32'h100 * (p + 1));
            fx_size[p] = WORD;
            fx_type[p] = SINGLE;
            fx_prot[p] = PROT_DATA;
            fx_we[p]   = p[0];
            fx_d[p]    = DW'(32'hD0 + p);
        end
        for (int p = 0; p < 3; p++) begin
            rr_stb[p]  = 1'b0;
            rr_lock[p] = 1'b0;
            rr_adri[p] = AW'(32'h010 * (p + 1));
            rr_size[p] = HWORD;
            rr_type[p] = INCR;
            rr_prot[p] = PROT_PRIVILEGED;
            rr_we[p]   = p[0];
            rr_d[p]    = DW'(32'hD0 + p);
        end
        rr_sack_i = 1'b0; rr_dack_i = 1'b0; rr_ack_i = 1'b0; rr_err_i = 1'b0;
        rr_adro_i = '0; rr_q_i = '0;
        fx_adro_i = 32'hA5A5_0004;
        fx_q_i    = 32'hCAFE_0001;
        fx_idle();

        // Reset with live requests: nothing may leave
        rst_n = 1'b0;
        fx_stb[0] = 1'b1; fx_stb[1] = 1'b1; fx_sack_i = 1'b1;
        #3;
        check("rst_stb_blocked", {61'd0, fx_stb_o, fx_stb_ack[0], fx_stb_ack[1]}, 64'd0);
        tick();
        check("rst_state", {62'd0, fx_busy, fx_orphan}, 64'd0);
        fx_idle();
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            {fx_stb[0], fx_stb[1], fx_lock[0], fx_lock[1],
             fx_sack_i, fx_dack_i, fx_ack_i, fx_err_i} = vecs[i].in;
            #3;
            check($sformatf("vec%0d", i),
                  {41'd0, fx_adr_o[11:0],
                   fx_stb_o, fx_stb_ack[0], fx_stb_ack[1], fx_d_ack[0], fx_d_ack[1],
                   fx_ack[0], fx_ack[1], fx_err[0], fx_err[1], fx_busy, fx_orphan},
                  {41'd0, vecs[i].adr, vecs[i].exp});
            tick();
        end

        check("bcast_q", {fx_q[0], fx_q[1]}, {32'hCAFE_0001, 32'hCAFE_0001});
        check("bcast_adro", {fx_adro[0], fx_adro[1]}, {32'hA5A5_0004, 32'hA5A5_0004});

        // Reset mid-operation discards the outstanding entry
        fx_idle();
        fx_stb[0] = 1'b1; fx_sack_i = 1'b1;
        #3;
        check("pre_rst_accept", {62'd0, fx_stb_o, fx_stb_ack[0]}, 64'd3);
        tick();
        rst_n = 1'b0;
        fx_stb[1] = 1'b1; fx_ack_i = 1'b1; fx_dack_i = 1'b1;
        #3;
        check("rst_outputs_gated",
              {56'd0, fx_stb_o, fx_stb_ack[0], fx_stb_ack[1], fx_ack[0], fx_ack[1],
               fx_err[0], fx_d_ack[0], fx_d_ack[1]}, 64'd0);
        tick();
        rst_n = 1'b1;
        fx_idle();
        #3;
        check("post_rst_clear", {62'd0, fx_busy, fx_orphan}, 64'd0);
        tick();
        fx_ack_i = 1'b1;
        #3;
        check("late_rsp_no_ack", {62'd0, fx_ack[0], fx_ack[1]}, 64'd0);
        tick();
        fx_ack_i = 1'b0;
        #3;
        check("late_rsp_orphan", {62'd0, fx_busy, fx_orphan}, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #3;
        check("orphan_cleared", {63'd0, fx_orphan}, 64'd0);
        tick();

        // Round-robin rotation 0,1,2,0,1,2 then in-order acks
        for (int k = 0; k < 6; k++) begin
            for (int p = 0; p < 3; p++) rr_stb[p] = 1'b1;
            rr_sack_i = 1'b1;
            #3;
            check($sformatf("rr_grant%0d", k),
                  {39'd0, rr_stb_o, rr_stb_ack[0], rr_stb_ack[1], rr_stb_ack[2],
                   rr_adr_o[11:0], rr_we_o, rr_d_o[7:0]},
                  {39'd0, 1'b1, 3'b100 >> (k % 3), 12'(12'h010 * ((k % 3) + 1)),
                   1'(k % 3 == 1), 8'(8'hD0 + (k % 3))});
            tick();
        end
        for (int p = 0; p < 3; p++) rr_stb[p] = 1'b0;
        rr_sack_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            rr_ack_i = 1'b1;
            #3;
            check($sformatf("rr_ack%0d", k),
                  {60'd0, rr_ack[0], rr_ack[1], rr_ack[2], rr_busy},
                  {60'd0, 3'b100 >> (k % 3), 1'b1});
            tick();
        end
        rr_ack_i = 1'b0;
        #3;
        check("rr_drained", {62'd0, rr_busy, rr_orphan}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
